// File: rtl/vending_fsm_param_if.sv
// ---------------------------------------------------------------------------
// vending_fsm_param_if
// Bundles the front-end strobes (coin acceptor / keypad) and the back-end
// status and pulse outputs (dispenser / display) of vending_fsm_param.
//
// Handshake: every input strobe (coin_valid, sel_valid, cancel, restock) is a
// single-cycle request with no ready signal. The controller samples strobes
// only while busy=0; a strobe presented while busy=1 is ignored and lost.
// Output pulses (coin_reject, sel_reject, vend_valid, change_valid) are
// single-cycle and carry no back-pressure.
//
// Optional feature macro: VEND_STOCK_EN adds the restock strobe.
//
// Modports
//   master : front end / back end side (drives strobes, observes outputs)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface vending_fsm_param_if #(
  parameter int NUM_DRINKS = 4,
  parameter int COIN_W     = 4,
  parameter int TOT_W      = 8
);
  localparam int SEL_W = ($clog2(NUM_DRINKS) > 0) ? $clog2(NUM_DRINKS) : 1;

  // front end
  logic                  coin_valid;
  logic [COIN_W-1:0]     coin_val;
  logic                  sel_valid;
  logic [SEL_W-1:0]      sel_idx;
  logic                  cancel;
`ifdef VEND_STOCK_EN
  logic                  restock;
`endif

  // back end
  logic                  busy;
  logic [TOT_W-1:0]      total_coin;
  logic [NUM_DRINKS-1:0] avail;
  logic                  coin_reject;
  logic                  sel_reject;
  logic                  vend_valid;
  logic [SEL_W-1:0]      vend_idx;
  logic                  change_valid;
  logic [TOT_W-1:0]      change;

  // debug view of the controller state (00 COIN, 01 SHOW, 10 BUY, 11 CHANGE)
  logic [1:0]            state_dbg;

  modport master (
    output coin_valid, coin_val, sel_valid, sel_idx, cancel,
`ifdef VEND_STOCK_EN
    output restock,
`endif
    input  busy, total_coin, avail, coin_reject, sel_reject,
    input  vend_valid, vend_idx, change_valid, change, state_dbg
  );

  modport slave (
    input  coin_valid, coin_val, sel_valid, sel_idx, cancel,
`ifdef VEND_STOCK_EN
    input  restock,
`endif
    output busy, total_coin, avail, coin_reject, sel_reject,
    output vend_valid, vend_idx, change_valid, change, state_dbg
  );
endinterface

// File: rtl/vending_fsm_param.sv
// ---------------------------------------------------------------------------
// vending_fsm_param
// Parametrised drink vending controller. Accepts multi-valued coins up to a
// credit ceiling, shows which drinks are affordable, dispenses a selected
// drink, and returns change (or a full refund on cancel).
//
// FSM: COIN (idle, samples strobes) -> SHOW (refresh avail) -> COIN
//      COIN -> BUY (dispense, deduct price) -> CHANGE (return rest) -> COIN
//      COIN -> CHANGE on cancel with nonzero credit.
//
// Optional feature macro: VEND_STOCK_EN adds per-drink stock counters and
// the restock strobe; without it stock is unlimited.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : vending_fsm_param_if.slave (strobes in; status, pulses,
//            change, state_dbg out)
// ---------------------------------------------------------------------------
module vending_fsm_param #(
  parameter int                          NUM_DRINKS = 4,
  parameter int                          COIN_W     = 4,
  parameter int                          TOT_W      = 8,
  parameter int                          MAX_TOTAL  = 200,
  parameter logic [NUM_DRINKS*TOT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10}
`ifdef VEND_STOCK_EN
  ,
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 10
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  vending_fsm_param_if.slave  bus
);
  localparam int SEL_W = ($clog2(NUM_DRINKS) > 0) ? $clog2(NUM_DRINKS) : 1;

  typedef enum logic [1:0] {
    ST_COIN   = 2'b00,
    ST_SHOW   = 2'b01,
    ST_BUY    = 2'b10,
    ST_CHANGE = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic [NUM_DRINKS-1:0] avail_q, avail_d;
  logic [SEL_W-1:0]      idx_q, idx_d;            // selection latched for BUY
  logic [SEL_W-1:0]      vend_idx_q, vend_idx_d;  // last dispensed drink
  logic                  coin_rej_q, coin_rej_d;
  logic                  sel_rej_q, sel_rej_d;

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0]    stock_q [NUM_DRINKS];
  logic [STOCK_W-1:0]    stock_d [NUM_DRINKS];
`endif

  function automatic logic [TOT_W-1:0] price_of(input int i);
    return PRICES[i*TOT_W +: TOT_W];
  endfunction

  // Credit sum is one bit wider than the total so a sum past 2**TOT_W-1
  // cannot wrap below the ceiling.
  logic [TOT_W:0]   credit_sum;
  logic             sel_ok;
  logic [TOT_W-1:0] buy_price;

  assign credit_sum = {1'b0, total_q} + (TOT_W+1)'(bus.coin_val);
  assign sel_ok     = (int'(bus.sel_idx) < NUM_DRINKS) && avail_q[bus.sel_idx];
  assign buy_price  = price_of(int'(idx_q));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COIN;
    else        state_q <= state_d;
  end

  // Next-state and next-data logic
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    avail_d    = avail_q;
    idx_d      = idx_q;
    vend_idx_d = vend_idx_q;
    coin_rej_d = 1'b0;
    sel_rej_d  = 1'b0;
`ifdef VEND_STOCK_EN
    stock_d    = stock_q;
`endif

    case (state_q)
      ST_COIN: begin
        // Priority cancel > coin > selection > restock. A lower-priority
        // strobe in the same cycle is dropped silently, except a coin
        // arriving with cancel, which is refused so it drops back out.
        if (bus.cancel) begin
          coin_rej_d = bus.coin_valid;
          if (total_q != '0) state_d = ST_CHANGE;
        end else if (bus.coin_valid) begin
          if (credit_sum <= (TOT_W+1)'(MAX_TOTAL)) begin
            total_d = credit_sum[TOT_W-1:0];
            state_d = ST_SHOW;
          end else begin
            coin_rej_d = 1'b1;
          end
        end else if (bus.sel_valid) begin
          if (sel_ok) begin
            idx_d   = bus.sel_idx;
            state_d = ST_BUY;
          end else begin
            sel_rej_d = 1'b1;
          end
        end
`ifdef VEND_STOCK_EN
        else if (bus.restock) begin
          for (int i = 0; i < NUM_DRINKS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
          state_d = ST_SHOW;
        end
`endif
      end

      ST_SHOW: begin
        for (int i = 0; i < NUM_DRINKS; i++) begin
`ifdef VEND_STOCK_EN
          avail_d[i] = (total_q >= price_of(i)) && (stock_q[i] != '0);
`else
          avail_d[i] = (total_q >= price_of(i));
`endif
        end
        state_d = ST_COIN;
      end

      ST_BUY: begin
        vend_idx_d = idx_q;
        // avail guaranteed total >= price; the guard keeps the subtraction
        // safe even so.
        total_d = (total_q >= buy_price) ? (total_q - buy_price) : '0;
`ifdef VEND_STOCK_EN
        if (stock_q[idx_q] != '0) stock_d[idx_q] = stock_q[idx_q] - STOCK_W'(1);
`endif
        state_d = ST_CHANGE;
      end

      ST_CHANGE: begin
        total_d = '0;
        avail_d = '0;
        state_d = ST_COIN;
      end

      default: state_d = ST_COIN;
    endcase
  end

  // Data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q    <= '0;
      avail_q    <= '0;
      idx_q      <= '0;
      vend_idx_q <= '0;
      coin_rej_q <= 1'b0;
      sel_rej_q  <= 1'b0;
    end else begin
      total_q    <= total_d;
      avail_q    <= avail_d;
      idx_q      <= idx_d;
      vend_idx_q <= vend_idx_d;
      coin_rej_q <= coin_rej_d;
      sel_rej_q  <= sel_rej_d;
    end
  end

`ifdef VEND_STOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DRINKS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_DRINKS; i++) stock_q[i] <= stock_d[i];
    end
  end
`endif

  // Outputs. vend_idx shows the latched selection during the BUY cycle and
  // then holds it until the next dispense.
  assign bus.busy         = (state_q != ST_COIN);
  assign bus.total_coin   = total_q;
  assign bus.avail        = avail_q;
  assign bus.coin_reject  = coin_rej_q;
  assign bus.sel_reject   = sel_rej_q;
  assign bus.vend_valid   = (state_q == ST_BUY);
  assign bus.vend_idx     = (state_q == ST_BUY) ? idx_q : vend_idx_q;
  assign bus.change_valid = (state_q == ST_CHANGE);
  assign bus.change       = (state_q == ST_CHANGE) ? total_q : '0;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_vending_fsm_param.sv
// ---------------------------------------------------------------------------
// tb_vending_fsm_param
// Directed bench for vending_fsm_param with default prices
// (drink0=10, drink1=15, drink2=20, drink3=25; ceiling 200).
// Pulse outputs are checked by a monitor against an expected-event queue;
// credit/avail levels are checked by the driver tasks after each step.
// With VEND_STOCK_EN defined the DUT is built with STOCK_INIT=1.
// ---------------------------------------------------------------------------
module tb_vending_fsm_param;
  localparam int W = 18;  // event = {type[17:16], idx[15:8], value[7:0]}
  localparam logic [1:0] EV_COIN_REJ = 2'd0;
  localparam logic [1:0] EV_SEL_REJ  = 2'd1;
  localparam logic [1:0] EV_VEND     = 2'd2;
  localparam logic [1:0] EV_CHANGE   = 2'd3;

  logic clk;
  logic rst_n;

  vending_fsm_param_if #(.NUM_DRINKS(4), .COIN_W(4), .TOT_W(8)) bus ();

  vending_fsm_param #(
    .NUM_DRINKS(4),
    .COIN_W(4),
    .TOT_W(8),
    .MAX_TOTAL(200)
`ifdef VEND_STOCK_EN
    , .STOCK_W(4)
    , .STOCK_INIT(1)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] mk_ev(input logic [1:0] t, input logic [7:0] idx,
                                         input logic [7:0] val);
    return {t, idx, val};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected pulse got %0h expected none (t=%0t)", name, act, $time);
    end else begin
      check(name, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  // Monitor: same-cycle pulses are taken in the fixed order
  // coin_reject, sel_reject, vend, change.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.coin_reject)  pop_check("coin_reject", mk_ev(EV_COIN_REJ, 8'd0, 8'd0));
      if (bus.sel_reject)   pop_check("sel_reject", mk_ev(EV_SEL_REJ, 8'd0, 8'd0));
      if (bus.vend_valid)   pop_check("vend", mk_ev(EV_VEND, 8'(bus.vend_idx), 8'd0));
      if (bus.change_valid) pop_check("change", mk_ev(EV_CHANGE, 8'd0, bus.change));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      step();
      n++;
    end
    if (bus.busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic put_coin(input logic [3:0] v, input bit exp_rej, input logic [7:0] exp_total,
                          input logic [3:0] exp_avail);
    wait_idle();
    if (exp_rej) exp_q.push_back(mk_ev(EV_COIN_REJ, 8'd0, 8'd0));
    bus.coin_valid = 1'b1;
    bus.coin_val   = v;
    step();
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    wait_idle();
    check("total_after_coin", 32'(bus.total_coin), 32'(exp_total));
    check("avail_after_coin", 32'(bus.avail), 32'(exp_avail));
  endtask

  task automatic select(input logic [1:0] idx, input bit exp_ok, input logic [7:0] exp_change);
    wait_idle();
    if (exp_ok) begin
      exp_q.push_back(mk_ev(EV_VEND, 8'(idx), 8'd0));
      exp_q.push_back(mk_ev(EV_CHANGE, 8'd0, exp_change));
    end else begin
      exp_q.push_back(mk_ev(EV_SEL_REJ, 8'd0, 8'd0));
    end
    bus.sel_valid = 1'b1;
    bus.sel_idx   = idx;
    step();
    bus.sel_valid = 1'b0;
    bus.sel_idx   = '0;
    wait_idle();
    if (exp_ok) begin
      check("total_after_vend", 32'(bus.total_coin), 32'd0);
      check("avail_after_vend", 32'(bus.avail), 32'd0);
    end
  endtask

  task automatic do_cancel(input bit with_coin, input logic [3:0] v, input bit exp_cv,
                           input logic [7:0] exp_change);
    wait_idle();
    if (with_coin) exp_q.push_back(mk_ev(EV_COIN_REJ, 8'd0, 8'd0));
    if (exp_cv)    exp_q.push_back(mk_ev(EV_CHANGE, 8'd0, exp_change));
    bus.cancel     = 1'b1;
    bus.coin_valid = with_coin;
    bus.coin_val   = v;
    step();
    bus.cancel     = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    wait_idle();
    check("total_after_cancel", 32'(bus.total_coin), 32'd0);
  endtask

  // Reload stock after a purchase so later steps see unlimited-like stock.
  task automatic refill();
`ifdef VEND_STOCK_EN
    wait_idle();
    bus.restock = 1'b1;
    step();
    bus.restock = 1'b0;
    wait_idle();
    check("avail_after_refill", 32'(bus.avail), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_total"}, 32'(bus.total_coin), 32'd0);
    check({tag, "_avail"}, 32'(bus.avail), 32'd0);
    check({tag, "_coin_rej"}, 32'(bus.coin_reject), 32'd0);
    check({tag, "_sel_rej"}, 32'(bus.sel_reject), 32'd0);
    check({tag, "_vend_valid"}, 32'(bus.vend_valid), 32'd0);
    check({tag, "_vend_idx"}, 32'(bus.vend_idx), 32'd0);
    check({tag, "_change_valid"}, 32'(bus.change_valid), 32'd0);
    check({tag, "_change"}, 32'(bus.change), 32'd0);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.sel_valid  = 1'b0;
    bus.sel_idx    = '0;
    bus.cancel     = 1'b0;
`ifdef VEND_STOCK_EN
    bus.restock    = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Coins 10,5 then drink 1 (price 15): exact payment, change 0 still pulses.
    put_coin(4'd10, 1'b0, 8'd10, 4'b0001);
    put_coin(4'd5,  1'b0, 8'd15, 4'b0011);
    select(2'd1, 1'b1, 8'd0);
    refill();

    // Coins 10,10,10 then drink 0 (price 10): change 20.
    put_coin(4'd10, 1'b0, 8'd10, 4'b0001);
    put_coin(4'd10, 1'b0, 8'd20, 4'b0111);
    put_coin(4'd10, 1'b0, 8'd30, 4'b1111);
    select(2'd0, 1'b1, 8'd20);
    refill();

    // Climb to 195 with 15s, then a coin of 10 would exceed the ceiling.
    for (int k = 0; k < 13; k++)
      put_coin(4'd15, 1'b0, 8'(15 * (k + 1)), (k == 0) ? 4'b0011 : 4'b1111);
    put_coin(4'd10, 1'b1, 8'd195, 4'b1111);
    do_cancel(1'b0, 4'd0, 1'b1, 8'd195);

    // Drink 3 (25) is not affordable at 10.
    put_coin(4'd10, 1'b0, 8'd10, 4'b0001);
    select(2'd3, 1'b0, 8'd0);
    check("total_after_sel_reject", 32'(bus.total_coin), 32'd10);
    put_coin(4'd10, 1'b0, 8'd20, 4'b0111);
    put_coin(4'd10, 1'b0, 8'd30, 4'b1111);
    // cancel + coin at 30: coin refused, full refund next cycle.
    do_cancel(1'b1, 4'd5, 1'b1, 8'd30);

    // Cancel with zero credit does nothing.
    do_cancel(1'b0, 4'd0, 1'b0, 8'd0);
    check("state_after_idle_cancel", 32'(bus.state_dbg), 32'd0);

    // Coin and selection together: coin taken, selection dropped without pulse.
    wait_idle();
    bus.coin_valid = 1'b1;
    bus.coin_val   = 4'd10;
    bus.sel_valid  = 1'b1;
    bus.sel_idx    = 2'd0;
    step();
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.sel_valid  = 1'b0;
    bus.sel_idx    = '0;
    wait_idle();
    check("total_coin_sel", 32'(bus.total_coin), 32'd10);
    check("avail_coin_sel", 32'(bus.avail), 32'b0001);
    do_cancel(1'b0, 4'd0, 1'b1, 8'd10);

`ifdef VEND_STOCK_EN
    // One unit of drink 0: second purchase refused until restock.
    refill();
    put_coin(4'd10, 1'b0, 8'd10, 4'b0001);
    select(2'd0, 1'b1, 8'd0);
    put_coin(4'd10, 1'b0, 8'd10, 4'b0000);
    select(2'd0, 1'b0, 8'd0);
    wait_idle();
    bus.restock = 1'b1;
    step();
    bus.restock = 1'b0;
    wait_idle();
    check("avail_after_restock", 32'(bus.avail), 32'b0001);
    do_cancel(1'b0, 4'd0, 1'b1, 8'd10);
`endif

    // Reset in the middle of BUY: no vend pulse reaches the monitor.
    put_coin(4'd10, 1'b0, 8'd10, 4'b0001);
    wait_idle();
    bus.sel_valid = 1'b1;
    bus.sel_idx   = 2'd0;
    step();
    bus.sel_valid = 1'b0;
    bus.sel_idx   = '0;
    check("state_mid_buy", 32'(bus.state_dbg), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_buy_reset");
    step();
    rst_n = 1'b1;
    step();

    // Recovery after reset.
    put_coin(4'd10, 1'b0, 8'd10, 4'b0001);
    select(2'd0, 1'b1, 8'd0);

    repeat (5) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
